// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the data-RAM responder and the memory stage.
// Word/lane sizes, request encoding and the byte-lane merge helper.
package data_ram_responder_pkg;

    localparam int DRAM_WORD_W = 32;
    localparam int DRAM_BYTES  = 4;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_LOAD  = 2'd1,
        REQ_STORE = 2'd2
    } dram_req_e;

    function automatic logic [DRAM_WORD_W-1:0] dram_merge(
        input logic [DRAM_WORD_W-1:0] old_word,
        input logic [DRAM_WORD_W-1:0] new_word,
        input logic [DRAM_BYTES-1:0]  be
    );
        logic [DRAM_WORD_W-1:0] res;
        res = old_word;
        for (int i = 0; i < DRAM_BYTES; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_ram_responder_sp_array.sv
// Single-port word array: one masked write or one registered read per cycle.
// Read data has no reset; contents are undefined until written.
module dram_sp_array
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic [DRAM_BYTES-1:0]  we,
    input  logic [ADDR_WIDTH-1:0]  idx,
    input  logic [DRAM_WORD_W-1:0] wdata,
    output logic [DRAM_WORD_W-1:0] rdata
);

    logic [DRAM_WORD_W-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we != '0) begin
                for (int i = 0; i < DRAM_BYTES; i++) begin
                    if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_ram_responder.sv
// Data-RAM responder: one-entry write buffer in front of a single-port array,
// with store-to-load forwarding and a held, one-cycle-latency load result.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   data_ram_en,
    input  logic [31:0]            data_ram_addr,
    input  logic [DRAM_BYTES-1:0]  data_ram_w_en,
    input  logic [DRAM_WORD_W-1:0] data_ram_w_data,
    output logic [DRAM_WORD_W-1:0] data_ram_r_data,
    output logic                   wbuf_pending
);

    dram_req_e req;
    logic [ADDR_WIDTH-1:0] idx;
    logic unused_addr_bits;

    logic                   wb_valid, wb_valid_n;
    logic [ADDR_WIDTH-1:0]  wb_idx, wb_idx_n;
    logic [DRAM_BYTES-1:0]  wb_be, wb_be_n;
    logic [DRAM_WORD_W-1:0] wb_data, wb_data_n;

    logic                   arr_en;
    logic [DRAM_BYTES-1:0]  arr_we;
    logic [ADDR_WIDTH-1:0]  arr_idx;
    logic [DRAM_WORD_W-1:0] arr_rdata;

    logic                   ld_q;
    logic                   fwd_hit_q;
    logic [DRAM_BYTES-1:0]  fwd_be_q;
    logic [DRAM_WORD_W-1:0] fwd_data_q;
    logic [DRAM_WORD_W-1:0] hold_q;
    logic [DRAM_WORD_W-1:0] ld_word;

    assign idx = data_ram_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{data_ram_addr[31:ADDR_WIDTH+2], data_ram_addr[1:0]};

    always_comb begin
        req = REQ_IDLE;
        if (data_ram_en) req = (data_ram_w_en == '0) ? REQ_LOAD : REQ_STORE;
    end

    always_comb begin
        arr_en     = 1'b0;
        arr_we     = '0;
        arr_idx    = idx;
        wb_valid_n = wb_valid;
        wb_idx_n   = wb_idx;
        wb_be_n    = wb_be;
        wb_data_n  = wb_data;
        unique case (req)
            REQ_LOAD: begin
                arr_en = 1'b1;
            end
            REQ_STORE: begin
                if (wb_valid && wb_idx == idx) begin
                    wb_be_n   = wb_be | data_ram_w_en;
                    wb_data_n = dram_merge(wb_data, data_ram_w_data, data_ram_w_en);
                end else begin
                    // A different word displaces the buffered store into the array.
                    if (wb_valid) begin
                        arr_en  = 1'b1;
                        arr_we  = wb_be;
                        arr_idx = wb_idx;
                    end
                    wb_valid_n = 1'b1;
                    wb_idx_n   = idx;
                    wb_be_n    = data_ram_w_en;
                    wb_data_n  = data_ram_w_data;
                end
            end
            default: begin
                if (wb_valid) begin
                    arr_en     = 1'b1;
                    arr_we     = wb_be;
                    arr_idx    = wb_idx;
                    wb_valid_n = 1'b0;
                end
            end
        endcase
        if (!reset) arr_en = 1'b0;
    end

    dram_sp_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .en   (arr_en),
        .we   (arr_we),
        .idx  (arr_idx),
        .wdata(wb_data),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_valid   <= 1'b0;
            wb_idx     <= '0;
            wb_be      <= '0;
            wb_data    <= '0;
            ld_q       <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_be_q   <= '0;
            fwd_data_q <= '0;
            hold_q     <= '0;
        end else begin
            wb_valid <= wb_valid_n;
            wb_idx   <= wb_idx_n;
            wb_be    <= wb_be_n;
            wb_data  <= wb_data_n;
            ld_q     <= (req == REQ_LOAD);
            if (req == REQ_LOAD) begin
                fwd_hit_q  <= wb_valid && (wb_idx == idx);
                fwd_be_q   <= wb_be;
                fwd_data_q <= wb_data;
            end
            if (ld_q) hold_q <= ld_word;
        end
    end

    // Result is built from registered array data and the snapshot taken at the request edge.
    assign ld_word = dram_merge(arr_rdata, fwd_data_q,
                                fwd_hit_q ? fwd_be_q : '0);

    assign data_ram_r_data = ld_q ? ld_word : hold_q;
    assign wbuf_pending    = wb_valid;

endmodule
